vibrato_lfo: RTL and testbench

Parametrised successor to the per-voice vibrato generator: a delayed, retriggerable pitch LFO with four waveforms, runtime depth, rate and delay, and an output centred on a fixed offset. It sits between the MIDI note tracker and the pitch/period calculator, one instance per voice. The calculator subtracts CENTER from vib_out to get a signed pitch-bend offset.

---
 rtl/vibrato_lfo.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_vibrato_lfo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vibrato_lfo.sv
// -----------------------------------------------------------------------------
// vibrato_lfo
//
// Per-voice delayed, retriggerable pitch LFO. After a trigger the block waits
// `delay` cycles, then advances a signed offset once every `rate`+1 cycles
// following one of four waveforms. The output is CENTER plus that offset, so
// the downstream pitch/period calculator recovers a signed bend by subtracting
// CENTER.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   en           block enable; low forces idle and blocks triggers
//   note_on      voice gate; low forces idle
//   note_repeat  single-cycle pulse: same note struck again (retrigger)
//   note_start   current MIDI note number; a change retriggers
//   mode         waveform: 0 triangle, 1 square, 2 saw up, 3 saw down
//   depth        peak offset in output LSBs, clamped to CENTER
//   rate         clk cycles per waveform step, minus one
//   delay        clk cycles from trigger to first step (0 = run at once)
//   vib_out      CENTER + signed offset (registered)
//   vib_start    high while the LFO is running (registered)
//   vib_step     one-cycle pulse on each offset update (registered)
// -----------------------------------------------------------------------------
module vibrato_lfo #(
  parameter int OUT_W   = 9,
  parameter int DEPTH_W = 8,
  parameter int DELAY_W = 24,
  parameter int STEP_W  = 18,
  parameter int CENTER  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               note_on,
  input  logic               note_repeat,
  input  logic [6:0]         note_start,
  input  logic [1:0]         mode,
  input  logic [DEPTH_W-1:0] depth,
  input  logic [STEP_W-1:0]  rate,
  input  logic [DELAY_W-1:0] delay,
  output logic [OUT_W-1:0]   vib_out,
  output logic               vib_start,
  output logic               vib_step
);

  // Offset carries one extra bit so that -deff .. +deff always fits.
  localparam int OFF_W = DEPTH_W + 1;

  localparam logic signed [OFF_W-1:0] OFF_ZERO = OFF_W'(0);
  localparam logic signed [OFF_W-1:0] OFF_ONE  = OFF_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Effective depth: the offset may never swing the output below zero.
  function automatic logic [DEPTH_W-1:0] clamp_depth(input logic [DEPTH_W-1:0] d);
    logic [DEPTH_W-1:0] lim;
    lim = DEPTH_W'(CENTER);
    if (d > lim) begin
      return lim;
    end else begin
      return d;
    end
  endfunction

  // Sign-extend (or truncate) the offset into the output adder width.
  function automatic logic [OUT_W-1:0] sext_offset(input logic signed [OFF_W-1:0] o);
    logic signed [OUT_W-1:0] r;
    r = OUT_W'(o);
    return r;
  endfunction

  // Registered state
  state_t                    state_r;
  logic [6:0]                note_reg_r;
  logic signed [OFF_W-1:0]   offset_r;
  logic                      dir_r;       // 1 = counting up
  logic                      pol_r;       // 1 = positive half of square
  logic [OFF_W-1:0]          sq_cnt_r;
  logic [STEP_W-1:0]         step_cnt_r;
  logic [DELAY_W-1:0]        delay_cnt_r;
  logic [OUT_W-1:0]          vib_out_r;
  logic                      vib_start_r;
  logic                      vib_step_r;

  // Next-state values
  state_t                    state_nxt_s;
  logic [6:0]                note_nxt_s;
  logic signed [OFF_W-1:0]   offset_nxt_s;
  logic                      dir_nxt_s;
  logic                      pol_nxt_s;
  logic [OFF_W-1:0]          sq_cnt_nxt_s;
  logic [STEP_W-1:0]         step_cnt_nxt_s;
  logic [DELAY_W-1:0]        delay_cnt_nxt_s;
  logic                      start_nxt_s;
  logic                      step_fire_s;

  // Derived combinational values
  logic [DEPTH_W-1:0]        deff_s;
  logic signed [OFF_W-1:0]   pos_deff_s;
  logic signed [OFF_W-1:0]   neg_deff_s;
  logic [OFF_W-1:0]          sq_last_s;
  logic                      trigger_s;
  logic                      gate_off_s;

  assign deff_s     = clamp_depth(depth);
  assign pos_deff_s = $signed({1'b0, deff_s});
  assign neg_deff_s = -pos_deff_s;
  // Square half-period in steps is 2*deff; the count runs 0 .. 2*deff-1.
  assign sq_last_s  = OFF_W'({deff_s, 1'b0}) - OFF_W'(1);

  assign trigger_s  = en && note_on &&
                      ((state_r == ST_IDLE) || (note_start != note_reg_r) || note_repeat);
  assign gate_off_s = !en || !note_on;

  // Next-state, counter and waveform-step logic
  always_comb begin
    state_nxt_s     = state_r;
    note_nxt_s      = note_reg_r;
    offset_nxt_s    = offset_r;
    dir_nxt_s       = dir_r;
    pol_nxt_s       = pol_r;
    sq_cnt_nxt_s    = sq_cnt_r;
    step_cnt_nxt_s  = step_cnt_r;
    delay_cnt_nxt_s = delay_cnt_r;
    start_nxt_s     = vib_start_r;
    step_fire_s     = 1'b0;

    if (trigger_s) begin
      // A trigger restarts everything and pre-empts any step this cycle.
      note_nxt_s      = note_start;
      offset_nxt_s    = OFF_ZERO;
      dir_nxt_s       = 1'b1;
      pol_nxt_s       = 1'b1;
      sq_cnt_nxt_s    = OFF_W'(0);
      step_cnt_nxt_s  = STEP_W'(0);
      delay_cnt_nxt_s = DELAY_W'(0);
      start_nxt_s     = 1'b0;
      if (delay == DELAY_W'(0)) begin
        state_nxt_s = ST_RUN;
      end else begin
        state_nxt_s = ST_DELAY;
      end
    end else if (gate_off_s) begin
      state_nxt_s     = ST_IDLE;
      note_nxt_s      = 7'd0;
      offset_nxt_s    = OFF_ZERO;
      start_nxt_s     = 1'b0;
      step_cnt_nxt_s  = STEP_W'(0);
      delay_cnt_nxt_s = DELAY_W'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Only a trigger leaves IDLE; hold the resting output.
          offset_nxt_s = OFF_ZERO;
        end

        ST_DELAY: begin
          delay_cnt_nxt_s = delay_cnt_r + DELAY_W'(1);
          if (delay_cnt_r == (delay - DELAY_W'(1))) begin
            state_nxt_s = ST_RUN;
            start_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_DELAY;
          end
        end

        ST_RUN: begin
          start_nxt_s = 1'b1;
          if (step_cnt_r == rate) begin
            step_cnt_nxt_s = STEP_W'(0);
            step_fire_s    = 1'b1;
            if (deff_s == DEPTH_W'(0)) begin
              offset_nxt_s = OFF_ZERO;
            end else if (offset_r > pos_deff_s) begin
              // Depth shrank below the current swing: snap to the new bound.
              offset_nxt_s = pos_deff_s;
            end else if (offset_r < neg_deff_s) begin
              offset_nxt_s = neg_deff_s;
            end else begin
              case (mode)
                2'd0: begin
                  // Triangle reverses on the peak step itself (no dwell).
                  if (dir_r) begin
                    if (offset_r >= pos_deff_s) begin
                      dir_nxt_s    = 1'b0;
                      offset_nxt_s = offset_r - OFF_ONE;
                    end else begin
                      offset_nxt_s = offset_r + OFF_ONE;
                    end
                  end else begin
                    if (offset_r <= neg_deff_s) begin
                      dir_nxt_s    = 1'b1;
                      offset_nxt_s = offset_r + OFF_ONE;
                    end else begin
                      offset_nxt_s = offset_r - OFF_ONE;
                    end
                  end
                end
                2'd1: begin
                  if (pol_r) begin
                    offset_nxt_s = pos_deff_s;
                  end else begin
                    offset_nxt_s = neg_deff_s;
                  end
                  // >= keeps the square sane if depth drops mid half-period.
                  if (sq_cnt_r >= sq_last_s) begin
                    pol_nxt_s    = !pol_r;
                    sq_cnt_nxt_s = OFF_W'(0);
                  end else begin
                    sq_cnt_nxt_s = sq_cnt_r + OFF_W'(1);
                  end
                end
                2'd2: begin
                  if (offset_r >= pos_deff_s) begin
                    offset_nxt_s = neg_deff_s;
                  end else begin
                    offset_nxt_s = offset_r + OFF_ONE;
                  end
                end
                2'd3: begin
                  if (offset_r <= neg_deff_s) begin
                    offset_nxt_s = pos_deff_s;
                  end else begin
                    offset_nxt_s = offset_r - OFF_ONE;
                  end
                end
                default: begin
                  offset_nxt_s = OFF_ZERO;
                end
              endcase
            end
          end else begin
            step_cnt_nxt_s = step_cnt_r + STEP_W'(1);
          end
        end

        default: begin
          state_nxt_s  = ST_IDLE;
          offset_nxt_s = OFF_ZERO;
          start_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; vib_out trails the offset by one cycle so it
  // moves exactly one cycle after the vib_step pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      note_reg_r  <= 7'd0;
      offset_r    <= OFF_ZERO;
      dir_r       <= 1'b1;
      pol_r       <= 1'b1;
      sq_cnt_r    <= OFF_W'(0);
      step_cnt_r  <= STEP_W'(0);
      delay_cnt_r <= DELAY_W'(0);
      vib_out_r   <= OUT_W'(CENTER);
      vib_start_r <= 1'b0;
      vib_step_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      note_reg_r  <= note_nxt_s;
      offset_r    <= offset_nxt_s;
      dir_r       <= dir_nxt_s;
      pol_r       <= pol_nxt_s;
      sq_cnt_r    <= sq_cnt_nxt_s;
      step_cnt_r  <= step_cnt_nxt_s;
      delay_cnt_r <= delay_cnt_nxt_s;
      vib_out_r   <= OUT_W'(CENTER) + sext_offset(offset_r);
      vib_start_r <= start_nxt_s;
      vib_step_r  <= step_fire_s;
    end
  end

  assign vib_out   = vib_out_r;
  assign vib_start = vib_start_r;
  assign vib_step  = vib_step_r;

endmodule

// File: tb/tb_vibrato_lfo.sv
// -----------------------------------------------------------------------------
// tb_vibrato_lfo
//
// Directed self-checking bench for vibrato_lfo with default parameters
// (CENTER = 12). Expected vib_out values for each waveform run are queued
// when the stimulus is applied and popped as the DUT signals each step.
// -----------------------------------------------------------------------------
module tb_vibrato_lfo;

  localparam int OUT_W   = 9;
  localparam int DEPTH_W = 8;
  localparam int DELAY_W = 24;
  localparam int STEP_W  = 18;
  localparam int CENTER  = 12;
  localparam int STEP_WAIT_LIMIT = 100;

  logic               clk;
  logic               reset;
  logic               en;
  logic               note_on;
  logic               note_repeat;
  logic [6:0]         note_start;
  logic [1:0]         mode;
  logic [DEPTH_W-1:0] depth;
  logic [STEP_W-1:0]  rate;
  logic [DELAY_W-1:0] delay;
  logic [OUT_W-1:0]   vib_out;
  logic               vib_start;
  logic               vib_step;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  vibrato_lfo #(
    .OUT_W   (OUT_W),
    .DEPTH_W (DEPTH_W),
    .DELAY_W (DELAY_W),
    .STEP_W  (STEP_W),
    .CENTER  (CENTER)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .note_on     (note_on),
    .note_repeat (note_repeat),
    .note_start  (note_start),
    .mode        (mode),
    .depth       (depth),
    .rate        (rate),
    .delay       (delay),
    .vib_out     (vib_out),
    .vib_start   (vib_start),
    .vib_step    (vib_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Consume the queued expectations: wait for each vib_step pulse, then
  // compare vib_out one cycle later.
  task automatic expect_steps(input string tag);
    int waited;
    int exp_v;
    while (exp_q.size() > 0) begin
      waited = 0;
      while (vib_step !== 1'b1 && waited < STEP_WAIT_LIMIT) begin
        tick();
        waited++;
      end
      check({tag, "_step_seen"}, (waited < STEP_WAIT_LIMIT) ? 32'd1 : 32'd0, 32'd1);
      if (waited >= STEP_WAIT_LIMIT) begin
        exp_q.delete();
      end else begin
        tick();
        exp_v = exp_q.pop_front();
        check(tag, 32'(vib_out), 32'(exp_v));
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; note_on = 1'b0; note_repeat = 1'b0;
    note_start = 7'd0; mode = 2'd0; depth = 8'd0; rate = 18'd0; delay = 24'd0;

    // ---- reset state
    repeat (2) tick();
    check("rst_vib_out", 32'(vib_out), 32'd12);
    check("rst_vib_start", 32'(vib_start), 32'd0);
    check("rst_vib_step", 32'(vib_step), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_vib_out", 32'(vib_out), 32'd12);

    // ---- triangle: delay 3, rate 1, depth 2, note 60
    en = 1'b1; note_on = 1'b1; note_start = 7'd60;
    mode = 2'd0; depth = 8'd2; rate = 18'd1; delay = 24'd3;
    tick();
    check("tri_start_t0", 32'(vib_start), 32'd0);
    tick(); tick();
    check("tri_start_t2", 32'(vib_start), 32'd0);
    tick();
    check("tri_start_t3", 32'(vib_start), 32'd1);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(13); exp_q.push_back(14); exp_q.push_back(13); exp_q.push_back(12);
    exp_q.push_back(11); exp_q.push_back(10); exp_q.push_back(11); exp_q.push_back(12);
    exp_q.push_back(13);
    expect_steps("tri");

    // ---- asynchronous reset mid-RUN, then release
    reset = 1'b1;
    #1;
    check("async_rst_out", 32'(vib_out), 32'd12);
    check("async_rst_start", 32'(vib_start), 32'd0);
    reset = 1'b0; note_on = 1'b0;
    tick(); tick();
    check("rel_out", 32'(vib_out), 32'd12);
    check("rel_start", 32'(vib_start), 32'd0);

    // ---- square: depth 3, rate 0, delay 0
    note_on = 1'b1; mode = 2'd1; depth = 8'd3; rate = 18'd0; delay = 24'd0;
    for (int i = 0; i < 6; i++) exp_q.push_back(15);
    for (int i = 0; i < 6; i++) exp_q.push_back(9);
    for (int i = 0; i < 2; i++) exp_q.push_back(15);
    expect_steps("sq3");

    // ---- note_repeat during a step cycle, depth 20 clamps to 12
    depth = 8'd20; note_repeat = 1'b1;
    tick();
    note_repeat = 1'b0;
    check("rep_step_suppressed", 32'(vib_step), 32'd0);
    check("rep_start_low", 32'(vib_start), 32'd0);
    tick();
    check("rep_out_center", 32'(vib_out), 32'd12);
    for (int i = 0; i < 24; i++) exp_q.push_back(24);
    for (int i = 0; i < 2; i++) exp_q.push_back(0);
    expect_steps("sq_clamp");

    // ---- note change 60 -> 62 retriggers with full delay; saw down depth 1
    note_start = 7'd62; mode = 2'd3; depth = 8'd1; delay = 24'd2;
    tick();
    check("chg_start_t0", 32'(vib_start), 32'd0);
    check("chg_step_t0", 32'(vib_step), 32'd0);
    tick();
    check("chg_out_t1", 32'(vib_out), 32'd12);
    check("chg_start_t1", 32'(vib_start), 32'd0);
    tick();
    check("chg_start_t2", 32'(vib_start), 32'd1);
    exp_q.push_back(11); exp_q.push_back(13); exp_q.push_back(12);
    exp_q.push_back(11); exp_q.push_back(13); exp_q.push_back(12);
    expect_steps("saw_dn");

    // ---- saw up depth 2 via note_repeat, no delay
    mode = 2'd2; depth = 8'd2; delay = 24'd0; note_repeat = 1'b1;
    tick();
    note_repeat = 1'b0;
    exp_q.push_back(13); exp_q.push_back(14); exp_q.push_back(10); exp_q.push_back(11);
    exp_q.push_back(12); exp_q.push_back(13); exp_q.push_back(14); exp_q.push_back(10);
    expect_steps("saw_up");

    // ---- one-cycle gate release, then fresh trigger with delay 3
    note_on = 1'b0; delay = 24'd3;
    tick();
    note_on = 1'b1;
    check("gate_start_low", 32'(vib_start), 32'd0);
    tick();
    check("gate_out_center", 32'(vib_out), 32'd12);
    check("gate_start_dly", 32'(vib_start), 32'd0);
    tick(); tick();
    check("gate_start_t3", 32'(vib_start), 32'd0);
    tick();
    check("gate_start_t4", 32'(vib_start), 32'd1);
    tick(); tick(); tick();
    check("gate_run_out", 32'(vib_out), 32'd14);

    // ---- one-cycle enable drop
    en = 1'b0;
    tick();
    en = 1'b1;
    check("en_start_low", 32'(vib_start), 32'd0);
    tick();
    check("en_out_center", 32'(vib_out), 32'd12);
    check("en_start_dly", 32'(vib_start), 32'd0);

    // ---- depth 0: output parked at CENTER while steps keep pulsing
    depth = 8'd0; delay = 24'd0; note_repeat = 1'b1;
    tick();
    note_repeat = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(12);
    expect_steps("depth0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
